// File: rtl/rc5_key_mix_ctrl.sv
// rc5_key_mix_ctrl
//   Sequencer for the RC5 key-schedule mixing pass. Assumes S[] is already
//   initialised in the S RAM and L[] is loaded from the key into the L RAM.
//   Owns port A of both RAMs and runs N_ITER read-modify-write iterations:
//     A = S[i] = (S[i] + A + B) <<< 3
//     B = L[j] = (L[j] + A + B) <<< (A + B)
//   The expanded table is left in the S RAM and oDone pulses for one cycle.
//
// Optional feature macro: RC5_KEYMIX_ABORT_EN
//   When defined, input iAbort is added. iAbort=1 in RD or WR returns to
//   IDLE on the next edge without an oDone pulse (the WR write still
//   happens in the cycle the abort is sampled).
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   iStart       start request, sampled in IDLE only
//   iAbort       early abort (only with RC5_KEYMIX_ABORT_EN)
//   oS_address   S RAM port-A address
//   oS_data      S RAM port-A write data
//   oS_we        S RAM port-A write enable
//   iS_data      S RAM port-A read data, one cycle after address
//   oL_address   L RAM port-A address
//   oL_data      L RAM port-A write data
//   oL_we        L RAM port-A write enable
//   iL_data      L RAM port-A read data, one cycle after address
//   oBusy        high while iterating
//   oDone        one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for iStart; all outputs 0
// RD    | present S[i] / L[j] addresses to the RAMs
// WR    | mix read data with A/B, write S[i] and L[j], advance i/j/k
// DONE  | one-cycle oDone pulse, then back to IDLE

module rc5_key_mix_ctrl #(
  parameter int W        = 32,
  parameter int T        = 26,
  parameter int C        = 4,
  parameter int T_LENGTH = $clog2(T),
  parameter int C_LENGTH = (C > 1) ? $clog2(C) : 1,
  parameter int N_ITER   = 3 * ((T > C) ? T : C)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
`ifdef RC5_KEYMIX_ABORT_EN
  input  logic                iAbort,
`endif
  output logic [T_LENGTH-1:0] oS_address,
  output logic [W-1:0]        oS_data,
  output logic                oS_we,
  input  logic [W-1:0]        iS_data,
  output logic [C_LENGTH-1:0] oL_address,
  output logic [W-1:0]        oL_data,
  output logic                oL_we,
  input  logic [W-1:0]        iL_data,
  output logic                oBusy,
  output logic                oDone
);

  localparam int RW  = $clog2(W);
  localparam int K_W = $clog2(N_ITER + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [T_LENGTH-1:0] i_q, i_d;
  logic [C_LENGTH-1:0] j_q, j_d;
  logic [K_W-1:0]      k_q, k_d;

  logic                abort_w;
  logic [W-1:0]        sum_s;
  logic [W-1:0]        a_new;
  logic [W-1:0]        sum_ab;
  logic [W-1:0]        sum_l;
  logic [W-1:0]        b_new;

`ifdef RC5_KEYMIX_ABORT_EN
  assign abort_w = iAbort;
`else
  assign abort_w = 1'b0;
`endif

  // Rotate by taking the upper half of the doubled word shifted left;
  // an amount of 0 returns x unchanged.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x,
                                        input logic [RW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

  // Mixing datapath; only meaningful in WR when the RAM read data is valid.
  always_comb begin
    sum_s  = iS_data + a_q + b_q;
    a_new  = rotl(sum_s, RW'(3));
    sum_ab = a_new + b_q;
    sum_l  = iL_data + sum_ab;
    b_new  = rotl(sum_l, sum_ab[RW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    oS_address = '0;
    oS_data    = '0;
    oS_we      = 1'b0;
    oL_address = '0;
    oL_data    = '0;
    oL_we      = 1'b0;
    oBusy      = 1'b0;
    oDone      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          a_d     = '0;
          b_d     = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = ST_RD;
        end
      end

      ST_RD: begin
        oS_address = i_q;
        oL_address = j_q;
        oBusy      = 1'b1;
        state_d    = abort_w ? ST_IDLE : ST_WR;
      end

      ST_WR: begin
        oS_address = i_q;
        oS_data    = a_new;
        oS_we      = 1'b1;
        oL_address = j_q;
        oL_data    = b_new;
        oL_we      = 1'b1;
        oBusy      = 1'b1;
        a_d        = a_new;
        b_d        = b_new;
        // Table sizes need not be powers of two, so wrap explicitly.
        i_d        = (i_q == T_LENGTH'(T - 1)) ? '0 : i_q + T_LENGTH'(1);
        j_d        = (j_q == C_LENGTH'(C - 1)) ? '0 : j_q + C_LENGTH'(1);
        k_d        = k_q + K_W'(1);
        if (abort_w) begin
          state_d = ST_IDLE;
        end else if (k_q == K_W'(N_ITER - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD;
        end
      end

      ST_DONE: begin
        oDone   = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
